// File: rtl/zmod_adc_spi_target.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module   : zmod_adc_spi_target                                         |
// | Purpose  : AD9648-style SPI configuration responder with per-channel   |
// |            shadow registers, running in the system clock domain.       |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module zmod_adc_spi_target #(
  parameter logic [7:0] P_CHIP_ID     = 8'h88,
  parameter int         P_SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_sck,
  input  logic        i_cs,
  input  logic        i_sdio,
  output logic        o_sdo,
  output logic        o_sdo_oe,
  output logic [7:0]  o8_chselect,
  output logic [7:0]  o8_pwrmode_a,
  output logic [7:0]  o8_pwrmode_b,
  output logic [7:0]  o8_testmode_a,
  output logic [7:0]  o8_testmode_b,
  output logic [7:0]  o8_omode_a,
  output logic [7:0]  o8_omode_b,
  output logic        o_wr_valid,
  output logic [12:0] o13_wr_addr,
  output logic        o_frame_err
);

  localparam logic [12:0] c_addr_id    = 13'h001;
  localparam logic [12:0] c_addr_chsel = 13'h005;
  localparam logic [12:0] c_addr_pwr   = 13'h008;
  localparam logic [12:0] c_addr_test  = 13'h00D;
  localparam logic [12:0] c_addr_omode = 13'h014;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR    = 3'd1,
    S_WR     = 3'd2,
    S_RD     = 3'd3,
    S_DONE   = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t r_state;

  logic [P_SYNC_STAGES-1:0] r_sck_sync;
  logic [P_SYNC_STAGES-1:0] r_cs_sync;
  logic [P_SYNC_STAGES-1:0] r_sdio_sync;
  logic                     r_sck_prev;

  logic [4:0]  r_bit_cnt;
  logic [14:0] r_hdr;
  logic [6:0]  r_data;
  logic [7:0]  r_tx;
  logic        r_first_fall;
  logic        r_sdo_oe;
  logic        r_wr_valid;
  logic        r_frame_err;
  logic [12:0] r_wr_addr;

  logic [7:0]  r_chselect;
  logic [7:0]  r_pwrmode_a, r_pwrmode_b;
  logic [7:0]  r_testmode_a, r_testmode_b;
  logic [7:0]  r_omode_a, r_omode_b;

  logic        w_sck_s, w_cs_s, w_sdio_s, w_rise, w_fall;
  logic [15:0] w_hdr_next;
  logic [7:0]  w_data_next;
  logic [7:0]  w_rd_data;

  function automatic logic [7:0] chan_pick(input logic [1:0] sel,
                                           input logic [7:0] a,
                                           input logic [7:0] b);
    if (sel[0])      return a;
    else if (sel[1]) return b;
    else             return 8'h00;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sck_sync  <= '1;
      r_cs_sync   <= '1;
      r_sdio_sync <= '1;
      r_sck_prev  <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[P_SYNC_STAGES-2:0], i_sck};
      r_cs_sync   <= {r_cs_sync[P_SYNC_STAGES-2:0], i_cs};
      r_sdio_sync <= {r_sdio_sync[P_SYNC_STAGES-2:0], i_sdio};
      r_sck_prev  <= r_sck_sync[P_SYNC_STAGES-1];
    end
  end

  assign w_sck_s     = r_sck_sync[P_SYNC_STAGES-1];
  assign w_cs_s      = r_cs_sync[P_SYNC_STAGES-1];
  assign w_sdio_s    = r_sdio_sync[P_SYNC_STAGES-1];
  assign w_rise      = w_sck_s & ~r_sck_prev;
  assign w_fall      = ~w_sck_s & r_sck_prev;
  assign w_hdr_next  = {r_hdr, w_sdio_s};
  assign w_data_next = {r_data, w_sdio_s};

  // Readback is looked up from the header as it completes so tx is ready on RD entry
  always_comb begin
    w_rd_data = 8'h00;
    case (w_hdr_next[12:0])
      c_addr_id:    w_rd_data = P_CHIP_ID;
      c_addr_chsel: w_rd_data = r_chselect;
      c_addr_pwr:   w_rd_data = chan_pick(r_chselect[1:0], r_pwrmode_a, r_pwrmode_b);
      c_addr_test:  w_rd_data = chan_pick(r_chselect[1:0], r_testmode_a, r_testmode_b);
      c_addr_omode: w_rd_data = chan_pick(r_chselect[1:0], r_omode_a, r_omode_b);
      default:      w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= 5'd0;
      r_hdr        <= 15'd0;
      r_data       <= 7'd0;
      r_tx         <= 8'd0;
      r_first_fall <= 1'b0;
      r_sdo_oe     <= 1'b0;
      r_wr_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_wr_addr    <= 13'd0;
      r_chselect   <= 8'h03;
      r_pwrmode_a  <= 8'h00;
      r_pwrmode_b  <= 8'h00;
      r_testmode_a <= 8'h00;
      r_testmode_b <= 8'h00;
      r_omode_a    <= 8'h01;
      r_omode_b    <= 8'h01;
    end else begin
      r_wr_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!w_cs_s) begin
            r_state   <= S_HDR;
            r_bit_cnt <= 5'd0;
            r_hdr     <= 15'd0;
            r_data    <= 7'd0;
          end
        end
        S_HDR: begin
          if (w_rise) begin
            r_hdr     <= w_hdr_next[14:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd15) begin
              if (w_hdr_next[14:13] != 2'b00) begin
                r_state     <= S_IGNORE;
                r_frame_err <= 1'b1;
              end else if (w_hdr_next[15]) begin
                r_state      <= S_RD;
                r_tx         <= w_rd_data;
                r_sdo_oe     <= 1'b1;
                r_first_fall <= 1'b1;
              end else begin
                r_state <= S_WR;
              end
            end
          end else if (w_cs_s) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
          end
        end
        S_WR: begin
          // Rise wins over a simultaneous deselect so the final bit still commits
          if (w_rise) begin
            r_data    <= w_data_next[6:0];
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              case (r_hdr[12:0])
                c_addr_chsel: r_chselect <= w_data_next;
                c_addr_pwr: begin
                  if (r_chselect[0]) r_pwrmode_a <= w_data_next;
                  if (r_chselect[1]) r_pwrmode_b <= w_data_next;
                end
                c_addr_test: begin
                  if (r_chselect[0]) r_testmode_a <= w_data_next;
                  if (r_chselect[1]) r_testmode_b <= w_data_next;
                end
                c_addr_omode: begin
                  if (r_chselect[0]) r_omode_a <= w_data_next;
                  if (r_chselect[1]) r_omode_b <= w_data_next;
                end
                default: ;
              endcase
              r_wr_valid <= 1'b1;
              r_wr_addr  <= r_hdr[12:0];
              r_state    <= S_DONE;
            end
          end else if (w_cs_s) begin
            r_state     <= S_IDLE;
            r_frame_err <= 1'b1;
          end
        end
        S_RD: begin
          if (w_rise) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              r_state  <= S_DONE;
              r_sdo_oe <= 1'b0;
            end
          end else if (w_fall) begin
            // The fall right after the header leaves bit 7 in place for the first data rise
            if (r_first_fall) r_first_fall <= 1'b0;
            else              r_tx         <= {r_tx[6:0], 1'b0};
          end else if (w_cs_s) begin
            r_state     <= S_IDLE;
            r_sdo_oe    <= 1'b0;
            r_frame_err <= 1'b1;
          end
        end
        S_DONE, S_IGNORE: begin
          if (w_cs_s) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_sdo         = r_sdo_oe & r_tx[7];
  assign o_sdo_oe      = r_sdo_oe;
  assign o_wr_valid    = r_wr_valid;
  assign o13_wr_addr   = r_wr_addr;
  assign o_frame_err   = r_frame_err;
  assign o8_chselect   = r_chselect;
  assign o8_pwrmode_a  = r_pwrmode_a;
  assign o8_pwrmode_b  = r_pwrmode_b;
  assign o8_testmode_a = r_testmode_a;
  assign o8_testmode_b = r_testmode_b;
  assign o8_omode_a    = r_omode_a;
  assign o8_omode_b    = r_omode_b;

endmodule
`default_nettype wire

// File: tb/tb_zmod_adc_spi_target.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module   : tb_zmod_adc_spi_target                                      |
// | Purpose  : Scoreboard bench for zmod_adc_spi_target with a register    |
// |            file reference model and randomized SPI frames.             |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_zmod_adc_spi_target;

  localparam int K_WR = 0, K_ERR = 1, K_RD = 2;
  localparam int M_FULL = 0, M_ABORT = 1, M_RESET = 2, M_CSLAST = 3;
  localparam logic [55:0] RESET_REGS = {8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h01};

  typedef struct packed {
    logic [1:0]  kind;
    logic [12:0] addr;
    logic [7:0]  rd;
    logic [55:0] regs;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, sck = 1'b1, cs = 1'b1, sdio = 1'b0;
  logic sdo, sdo_oe, wr_valid, frame_err;
  logic [7:0] chsel, pwr_a, pwr_b, test_a, test_b, om_a, om_b;
  logic [12:0] wr_addr;

  int n_cmp = 0, n_fail = 0;
  exp_t q[$];

  logic [7:0] m_chsel, m_pa, m_pb, m_ta, m_tb, m_oa, m_ob;

  always #5 clk = ~clk;

  zmod_adc_spi_target #(.P_CHIP_ID(8'h88), .P_SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .i_sck(sck), .i_cs(cs), .i_sdio(sdio),
    .o_sdo(sdo), .o_sdo_oe(sdo_oe),
    .o8_chselect(chsel), .o8_pwrmode_a(pwr_a), .o8_pwrmode_b(pwr_b),
    .o8_testmode_a(test_a), .o8_testmode_b(test_b),
    .o8_omode_a(om_a), .o8_omode_b(om_b),
    .o_wr_valid(wr_valid), .o13_wr_addr(wr_addr), .o_frame_err(frame_err)
  );

  wire [55:0] dut_regs = {chsel, pwr_a, pwr_b, test_a, test_b, om_a, om_b};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    {m_chsel, m_pa, m_pb, m_ta, m_tb, m_oa, m_ob} = RESET_REGS;
  endtask

  function automatic logic [55:0] model_regs();
    return {m_chsel, m_pa, m_pb, m_ta, m_tb, m_oa, m_ob};
  endfunction

  task automatic model_write(input logic [12:0] a, input logic [7:0] d);
    bit to_a = m_chsel[0], to_b = m_chsel[1];
    if (a == 13'h005) m_chsel = d;
    if (a == 13'h008) begin if (to_a) m_pa = d; if (to_b) m_pb = d; end
    if (a == 13'h00D) begin if (to_a) m_ta = d; if (to_b) m_tb = d; end
    if (a == 13'h014) begin if (to_a) m_oa = d; if (to_b) m_ob = d; end
  endtask

  function automatic logic [7:0] model_read(input logic [12:0] a);
    logic [7:0] ca, cb;
    case (a)
      13'h001: return 8'h88;
      13'h005: return m_chsel;
      13'h008: begin ca = m_pa; cb = m_pb; end
      13'h00D: begin ca = m_ta; cb = m_tb; end
      13'h014: begin ca = m_oa; cb = m_ob; end
      default: return 8'h00;
    endcase
    if (m_chsel[0]) return ca;
    if (m_chsel[1]) return cb;
    return 8'h00;
  endfunction

  // ---------------- SPI initiator ----------------
  task automatic half();
    repeat (8) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_regs"}, dut_regs, RESET_REGS);
    check({tag, "_sdo_oe"}, sdo_oe, 0);
    check({tag, "_sdo"}, sdo, 0);
    check({tag, "_pulses"}, {wr_valid, frame_err}, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  task automatic spi_frame(input logic [23:0] bits, input int mode, input int stop_at);
    cs = 1'b0;
    half();
    for (int i = 0; i < 24; i++) begin
      if ((mode == M_ABORT || mode == M_RESET) && i == stop_at) break;
      sck = 1'b0; sdio = bits[23-i];
      half();
      sck = 1'b1;
      if (mode == M_CSLAST && i == 23) cs = 1'b1;
      half();
    end
    if (mode == M_RESET) begin
      rst = 1'b1;
      #1;
      check_reset_outputs("midframe_reset");
      model_reset();
      cs = 1'b1; sck = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
    end
    cs = 1'b1;
    half(); half();
  endtask

  task automatic do_write(input logic [12:0] a, input logic [7:0] d);
    model_write(a, d);
    q.push_back('{kind: 2'(K_WR), addr: a, rd: 8'h00, regs: model_regs()});
    spi_frame({3'b000, a, d}, M_FULL, 0);
  endtask

  task automatic do_read(input logic [12:0] a);
    q.push_back('{kind: 2'(K_RD), addr: a, rd: model_read(a), regs: model_regs()});
    spi_frame({3'b100, a, 8'h00}, M_FULL, 0);
  endtask

  // ---------------- monitors ----------------
  logic [7:0] rd_sh = 8'h00;
  int rd_n = 0;
  logic prev_oe = 1'b0;
  logic [55:0] prev_regs = RESET_REGS;

  always @(posedge sck) begin
    if (sdo_oe) begin
      rd_sh = {rd_sh[6:0], sdo};
      rd_n++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (wr_valid || frame_err) begin
        if (q.size() == 0) check("unexpected_event", {wr_valid, frame_err}, 0);
        else begin
          e = q.pop_front();
          check("event_kind", wr_valid ? K_WR : K_ERR, e.kind);
          if (e.kind == K_WR) check("wr_addr", wr_addr, e.addr);
          check("regs_at_event", dut_regs, e.regs);
        end
      end
      if (dut_regs !== prev_regs) check("regs_change_only_on_write", wr_valid, 1);
      if (!prev_oe && sdo_oe) rd_n = 0;
      if (prev_oe && !sdo_oe) begin
        if (q.size() == 0) check("unexpected_read", 1, 0);
        else begin
          e = q.pop_front();
          check("read_kind", K_RD, e.kind);
          check("read_bits_in_oe", rd_n, 8);
          check("read_data", rd_sh, e.rd);
          check("regs_after_read", dut_regs, e.regs);
        end
      end
    end
    prev_regs = dut_regs;
    prev_oe = sdo_oe;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [12:0] addr_tab [6];
    logic [12:0] seq_a [8];
    logic [7:0]  seq_d [8];
    addr_tab = '{13'h001, 13'h005, 13'h008, 13'h00D, 13'h014, 13'h0FF};
    seq_a = '{13'h005, 13'h008, 13'h005, 13'h014, 13'h005, 13'h014, 13'h005, 13'h008};
    seq_d = '{8'h03, 8'h3C, 8'h01, 8'h31, 8'h02, 8'h21, 8'h03, 8'h00};
    model_reset();

    repeat (5) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check_reset_outputs("idle");

    for (int i = 0; i < 8; i++) do_write(seq_a[i], seq_d[i]);
    check("seq_omode_a", om_a, 8'h31);
    check("seq_omode_b", om_b, 8'h21);
    check("seq_pwrmode", {pwr_a, pwr_b}, 16'h0000);
    check("seq_chselect", chsel, 8'h03);

    do_read(13'h001);

    q.push_back('{kind: 2'(K_ERR), addr: 13'h0, rd: 8'h00, regs: model_regs()});
    spi_frame({16'h0008, 8'hAA}, M_ABORT, 12);
    check("abort_pwrmode", {pwr_a, pwr_b}, 16'h0000);
    do_write(13'h008, 8'h55);

    q.push_back('{kind: 2'(K_ERR), addr: 13'h0, rd: 8'h00, regs: model_regs()});
    spi_frame({16'h2008, 8'h77}, M_FULL, 0);
    check("w01_pwrmode", {pwr_a, pwr_b}, 16'h5555);

    model_write(13'h00D, 8'hC3);
    q.push_back('{kind: 2'(K_WR), addr: 13'h00D, rd: 8'h00, regs: model_regs()});
    spi_frame({16'h000D, 8'hC3}, M_CSLAST, 0);

    spi_frame({16'h0014, 8'h99}, M_RESET, 20);
    do_write(13'h014, 8'h5A);
    check("post_reset_omode", {om_a, om_b}, 16'h5A5A);

    for (int i = 0; i < 40; i++) begin
      logic [12:0] a;
      a = addr_tab[$urandom_range(0, 5)];
      if (a == 13'h0FF) a = 13'($urandom);
      if ($urandom_range(0, 2) == 0) do_read(a);
      else do_write(a, 8'($urandom));
    end
    for (int i = 0; i < 4; i++) do_read(addr_tab[i+1]);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    check("queue_drained", q.size(), 0);
    check("final_regs", dut_regs, model_regs());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
